// File: rtl/mcont_chnbuf_rd_sched_pkg.sv
// Shared types and constants for the channel-buffer read scheduler.
package mcont_chnbuf_rd_sched_pkg;

  localparam int NUM_CHN = 16;
  localparam int CHN_W   = 4;
  localparam int BURST_W = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_SEL,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // A burst length field of zero stands for the maximum burst of 128 words.
  function automatic logic [7:0] burst_len(input logic [BURST_W-1:0] bw);
    return (bw == '0) ? 8'd128 : {1'b0, bw};
  endfunction

endpackage

// File: rtl/mcont_chnbuf_rd_sched_if.sv
// Request/strobe bundle between channel request logic, the scheduler and
// the per-channel buffer read stages.
interface mcont_chnbuf_rd_sched_if;
  import mcont_chnbuf_rd_sched_pkg::*;

  logic [NUM_CHN-1:0] chn_want;
  logic [NUM_CHN-1:0] chn_urgent;
  logic [BURST_W-1:0] burst_words;
  logic               seq_ready;
  logic [NUM_CHN-1:0] chn_ack;
  logic [CHN_W-1:0]   ext_buf_rchn;
  logic               ext_buf_rd;
  logic               seq_done;
  logic               busy;
  logic [CHN_W-1:0]   cur_chn;

  // Requester / sequencer side.
  modport master (
    output chn_want, chn_urgent, burst_words, seq_ready,
    input  chn_ack, ext_buf_rchn, ext_buf_rd, seq_done, busy, cur_chn
  );

  // Scheduler side.
  modport slave (
    input  chn_want, chn_urgent, burst_words, seq_ready,
    output chn_ack, ext_buf_rchn, ext_buf_rd, seq_done, busy, cur_chn
  );

endinterface

// File: rtl/mcont_rr_prio_pick.sv
// Combinational 16-way round-robin pick with urgent override. The search
// starts just above rr_ptr_i and wraps, so rr_ptr_i itself has lowest priority.
module mcont_rr_prio_pick
  import mcont_chnbuf_rd_sched_pkg::*;
(
  input  logic [NUM_CHN-1:0] elig_i,
  input  logic [NUM_CHN-1:0] urg_i,
  input  logic [CHN_W-1:0]   rr_ptr_i,
  output logic [CHN_W-1:0]   win_o,
  output logic               vld_o
);

  logic [NUM_CHN-1:0] pool;

  // Scan from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    pool  = (urg_i != '0) ? urg_i : elig_i;
    win_o = '0;
    vld_o = 1'b0;
    for (int i = NUM_CHN; i >= 1; i--) begin
      if (pool[rr_ptr_i + CHN_W'(i)]) begin
        win_o = rr_ptr_i + CHN_W'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mcont_chnbuf_rd_sched.sv
// Shares the 64-bit channel-buffer read path among up to 16 channels:
// arbitrates, leads the read strobes with a stable select, counts the burst
// and waits out the read pipeline before reporting completion.
module mcont_chnbuf_rd_sched
  import mcont_chnbuf_rd_sched_pkg::*;
#(
  parameter logic [NUM_CHN-1:0] CHN_MASK        = 16'hffff,
  parameter int                 MAX_CHN_LATENCY = 2
) (
  input logic                     clk,
  input logic                     rst,
  mcont_chnbuf_rd_sched_if.slave  bus
);

  // Select register + read register + channel latency + output register.
  localparam logic [7:0] DRAIN_LEN = 8'(MAX_CHN_LATENCY + 3);

  state_e             state_q, state_d;
  logic [CHN_W-1:0]   cur_chn_q, cur_chn_d;
  logic [CHN_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [NUM_CHN-1:0] elig, urg;
  logic [CHN_W-1:0]   win;
  logic               win_vld;

  assign elig = bus.chn_want & CHN_MASK;
  assign urg  = elig & bus.chn_urgent;

  mcont_rr_prio_pick u_pick (
    .elig_i   (elig),
    .urg_i    (urg),
    .rr_ptr_i (rr_ptr_q),
    .win_o    (win),
    .vld_o    (win_vld)
  );

  // State, served channel, round-robin pointer and shared word/drain counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cur_chn_q <= '0;
      rr_ptr_q  <= '1;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cur_chn_q <= cur_chn_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic; the winner is captured on entry so it is stable for the whole GRANT cycle.
  always_comb begin
    state_d   = state_q;
    cur_chn_d = cur_chn_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_vld && bus.seq_ready) begin
          state_d   = ST_GRANT;
          cur_chn_d = win;
          rr_ptr_d  = win;
        end
      end
      ST_GRANT: begin
        cnt_d   = burst_len(bus.burst_words);
        state_d = ST_SEL;
      end
      ST_SEL: begin
        state_d = ST_READ;
      end
      ST_READ: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_LEN;
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd2) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.chn_ack      = (state_q == ST_GRANT) ? ((NUM_CHN'(1) << cur_chn_q) & CHN_MASK) : '0;
  assign bus.ext_buf_rchn = cur_chn_q;
  assign bus.cur_chn      = cur_chn_q;
  assign bus.ext_buf_rd   = (state_q == ST_READ);
  assign bus.seq_done     = (state_q == ST_DONE);
  assign bus.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mcont_chnbuf_rd_sched.sv
// Directed bench for the channel-buffer read scheduler and its picker.
module tb_mcont_chnbuf_rd_sched;
  import mcont_chnbuf_rd_sched_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mcont_chnbuf_rd_sched_if ifa();
  mcont_chnbuf_rd_sched_if ifb();

  mcont_chnbuf_rd_sched #(.CHN_MASK(16'hffff), .MAX_CHN_LATENCY(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  mcont_chnbuf_rd_sched #(.CHN_MASK(16'hfffe), .MAX_CHN_LATENCY(2)) u_dut_mask (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  logic [15:0] p_e, p_u;
  logic [3:0]  p_rr, p_win;
  logic        p_vld;

  mcont_rr_prio_pick u_pick (
    .elig_i   (p_e),
    .urg_i    (p_u),
    .rr_ptr_i (p_rr),
    .win_o    (p_win),
    .vld_o    (p_vld)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int chn;
    int len;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   m_cyc = 0, m_ack_cyc = 0, m_first_rd = 0, m_last_rd = 0;
  int   m_rd_cnt = 0, m_active = 0, m_chn = 0, m_len = 0;
  int   seq_done_cnt = 0;
  logic [15:0] exp_ack;
  logic auto_drop = 1'b0;

  // Scoreboard monitor on the main DUT: pop the expected grant at each ack, check the sequence at seq_done.
  always @(negedge clk) begin
    m_cyc++;
    if (rst) begin
      m_active = 0;
      m_rd_cnt = 0;
    end else begin
      if (ifa.chn_ack != '0) begin
        chk("ack_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e     = exp_q.pop_front();
          m_chn = e.chn;
          m_len = e.len;
        end
        exp_ack        = '0;
        exp_ack[m_chn] = 1'b1;
        chk("ack_chn", 32'(ifa.chn_ack), 32'(exp_ack));
        chk("grant_rchn", 32'(ifa.ext_buf_rchn), m_chn);
        chk("grant_cur_chn", 32'(ifa.cur_chn), m_chn);
        chk("grant_busy", 32'(ifa.busy), 32'd1);
        m_active  = 1;
        m_rd_cnt  = 0;
        m_ack_cyc = m_cyc;
      end
      if (ifa.ext_buf_rd) begin
        if (m_rd_cnt == 0) begin
          chk("sel_lead", m_cyc - m_ack_cyc, 32'd2);
          chk("rd_rchn", 32'(ifa.ext_buf_rchn), m_chn);
          m_first_rd = m_cyc;
        end
        m_rd_cnt++;
        m_last_rd = m_cyc;
      end
      if (ifa.seq_done) begin
        chk("done_in_seq", m_active, 32'd1);
        chk("burst_len", m_rd_cnt, m_len);
        chk("rd_contig", m_last_rd - m_first_rd + 1, m_len);
        chk("drain_gap", m_cyc - m_last_rd, 32'd5);
        chk("done_busy", 32'(ifa.busy), 32'd1);
        chk("done_rchn", 32'(ifa.ext_buf_rchn), m_chn);
        seq_done_cnt++;
        m_active = 0;
      end
    end
  end

  // One cycle: sample point after the falling edge; granted requesters drop their request.
  task automatic step();
    @(negedge clk);
    #1;
    if (auto_drop) ifa.chn_want = ifa.chn_want & ~ifa.chn_ack;
  endtask

  task automatic wait_done(input int target, input int limit);
    int n = 0;
    while (seq_done_cnt < target && n < limit) begin
      step();
      n++;
    end
    chk("seq_done_timeout", 32'(seq_done_cnt >= target), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic pick_chk(input logic [15:0] e_v, input logic [15:0] u_v, input logic [3:0] rr_v,
                          input logic [3:0] win_v, input logic vld_v);
    p_e  = e_v;
    p_u  = u_v;
    p_rr = rr_v;
    #1;
    chk("pick_vld", 32'(p_vld), 32'(vld_v));
    if (vld_v) chk("pick_win", 32'(p_win), 32'(win_v));
  endtask

  initial begin
    int base;
    int n;
    ifa.chn_want = '0; ifa.chn_urgent = '0; ifa.burst_words = '0; ifa.seq_ready = 1'b0;
    ifb.chn_want = '0; ifb.chn_urgent = '0; ifb.burst_words = 7'd1; ifb.seq_ready = 1'b1;

    // Standalone picker: wrap-around, urgent override, self lowest priority, empty set.
    pick_chk(16'h0000, 16'h0000, 4'd0,  4'd0,  1'b0);
    pick_chk(16'h0109, 16'h0000, 4'd15, 4'd0,  1'b1);
    pick_chk(16'h0109, 16'h0000, 4'd0,  4'd3,  1'b1);
    pick_chk(16'h0109, 16'h0000, 4'd8,  4'd0,  1'b1);
    pick_chk(16'h000f, 16'h0004, 4'd0,  4'd2,  1'b1);
    pick_chk(16'h000f, 16'h0004, 4'd2,  4'd2,  1'b1);
    pick_chk(16'h8000, 16'h0000, 4'd15, 4'd15, 1'b1);

    // Reset state.
    step();
    step();
    chk("rst_ack",  32'(ifa.chn_ack), 32'd0);
    chk("rst_rchn", 32'(ifa.ext_buf_rchn), 32'd0);
    chk("rst_rd",   32'(ifa.ext_buf_rd), 32'd0);
    chk("rst_done", 32'(ifa.seq_done), 32'd0);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_cur",  32'(ifa.cur_chn), 32'd0);
    rst = 1'b0;

    // Single channel, 4-word burst.
    auto_drop = 1'b1;
    base = seq_done_cnt;
    exp_q.push_back('{chn: 5, len: 4});
    ifa.burst_words = 7'd4;
    ifa.seq_ready   = 1'b1;
    ifa.chn_want    = 16'h0020;
    wait_done(base + 1, 40);
    step();
    chk("idle_busy", 32'(ifa.busy), 32'd0);
    chk("rchn_hold", 32'(ifa.ext_buf_rchn), 32'd5);

    // Round-robin with requests held.
    do_reset();
    auto_drop = 1'b0;
    base = seq_done_cnt;
    exp_q.push_back('{chn: 0, len: 1});
    exp_q.push_back('{chn: 3, len: 1});
    exp_q.push_back('{chn: 8, len: 1});
    exp_q.push_back('{chn: 0, len: 1});
    exp_q.push_back('{chn: 3, len: 1});
    ifa.burst_words = 7'd1;
    ifa.chn_want    = 16'h0109;
    wait_done(base + 5, 100);
    ifa.chn_want = '0;

    // Urgent override after channel 0 has been served.
    do_reset();
    auto_drop = 1'b1;
    base = seq_done_cnt;
    exp_q.push_back('{chn: 0, len: 1});
    ifa.chn_want = 16'h000f;
    wait_done(base + 1, 40);
    ifa.chn_urgent = 16'h0004;
    exp_q.push_back('{chn: 2, len: 1});
    exp_q.push_back('{chn: 3, len: 1});
    exp_q.push_back('{chn: 1, len: 1});
    wait_done(base + 4, 100);
    ifa.chn_urgent = '0;

    // Burst field 0 means 128 words.
    do_reset();
    base = seq_done_cnt;
    exp_q.push_back('{chn: 7, len: 128});
    ifa.burst_words = 7'd0;
    ifa.chn_want    = 16'h0080;
    wait_done(base + 1, 200);

    // Masked channel is never granted; an enabled neighbour is.
    ifb.chn_want = 16'h0001;
    repeat (6) step();
    chk("mask_busy", 32'(ifb.busy), 32'd0);
    chk("mask_ack",  32'(ifb.chn_ack), 32'd0);
    ifb.chn_want = 16'h0003;
    n = 0;
    while (ifb.chn_ack == '0 && n < 20) begin
      step();
      n++;
    end
    chk("mask_grant", 32'(ifb.chn_ack), 32'h0002);
    ifb.chn_want = '0;

    // Flow control: hold in IDLE without seq_ready; dropping it mid-burst is ignored.
    do_reset();
    base = seq_done_cnt;
    ifa.seq_ready   = 1'b0;
    ifa.burst_words = 7'd8;
    ifa.chn_want    = 16'h0040;
    repeat (4) step();
    chk("fc_hold_busy", 32'(ifa.busy), 32'd0);
    chk("fc_hold_ack",  32'(ifa.chn_ack), 32'd0);
    exp_q.push_back('{chn: 6, len: 8});
    @(posedge clk);
    #1;
    ifa.seq_ready = 1'b1;
    step();
    chk("fc_before_edge", 32'(ifa.busy), 32'd0);
    step();
    chk("fc_grant_next_edge", 32'(ifa.chn_ack), 32'h0040);
    n = 0;
    while (!ifa.ext_buf_rd && n < 20) begin
      step();
      n++;
    end
    chk("fc_rd_start", 32'(ifa.ext_buf_rd), 32'd1);
    ifa.seq_ready = 1'b0;
    wait_done(base + 1, 40);
    ifa.seq_ready = 1'b1;

    // Asynchronous reset in the middle of a burst.
    do_reset();
    exp_q.push_back('{chn: 1, len: 8});
    ifa.chn_want = 16'h0002;
    n = 0;
    while (m_rd_cnt < 3 && n < 30) begin
      step();
      n++;
    end
    chk("mid_rd_count", m_rd_cnt, 32'd3);
    base = seq_done_cnt;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rd",   32'(ifa.ext_buf_rd), 32'd0);
    chk("arst_busy", 32'(ifa.busy), 32'd0);
    chk("arst_rchn", 32'(ifa.ext_buf_rchn), 32'd0);
    chk("arst_ack",  32'(ifa.chn_ack), 32'd0);
    step();
    step();
    rst = 1'b0;
    chk("arst_no_done", seq_done_cnt, base);
    exp_q.push_back('{chn: 0, len: 1});
    exp_q.push_back('{chn: 4, len: 1});
    ifa.burst_words = 7'd1;
    ifa.chn_want    = 16'h0011;
    wait_done(base + 2, 60);
    repeat (4) step();
    chk("final_done_count", seq_done_cnt, base + 2);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
